// File: rtl/demux_buf_if.sv
// Handshake bundle for demux_buf: one steered input stream, two buffered
// output streams (A and B) and their pop counters.
interface demux_buf_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;

    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;

    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;

    logic [CNT_W-1:0] a_cnt;
    logic [CNT_W-1:0] b_cnt;

    // Block side: accepts the input stream, presents A/B streams and counters.
    modport slave (
        input  in_valid, in_data, in_sel, a_ready, b_ready,
        output in_ready, a_valid, a_data, b_valid, b_data, a_cnt, b_cnt
    );

    // Environment side: upstream producer plus both downstream consumers.
    modport master (
        output in_valid, in_data, in_sel, a_ready, b_ready,
        input  in_ready, a_valid, a_data, b_valid, b_data, a_cnt, b_cnt
    );
endinterface

// File: rtl/demux_buf.sv
// 1-to-2 steering buffer: each input word goes to FIFO A (in_sel=0) or
// FIFO B (in_sel=1). Each FIFO drains independently so one stalled consumer
// only blocks words headed for it. Index 0 is A, index 1 is B throughout.
module demux_buf #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    demux_buf_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem  [2][DEPTH];
    logic [PTR_W-1:0] r_wptr [2];
    logic [PTR_W-1:0] r_rptr [2];
    logic [OCC_W-1:0] r_occ  [2];
    logic [CNT_W-1:0] r_cnt  [2];

    logic             w_full       [2];
    logic             w_valid      [2];
    logic             w_sink_ready [2];
    logic             w_push       [2];
    logic             w_pop        [2];
    logic [WIDTH-1:0] w_head       [2];
    logic             w_in_ready;

    // Full/valid flags, steering decision and head-word selection.
    // A full FIFO refuses a push even when it pops in the same cycle.
    always_comb begin
        w_sink_ready[0] = bus.a_ready;
        w_sink_ready[1] = bus.b_ready;
        for (int k = 0; k < 2; k++) begin
            w_full[k]  = (r_occ[k] == OCC_W'(DEPTH));
            w_valid[k] = (r_occ[k] != '0);
            w_head[k]  = w_valid[k] ? r_mem[k][r_rptr[k]] : '0;
        end
        w_in_ready = bus.in_sel ? !w_full[1] : !w_full[0];
        for (int k = 0; k < 2; k++) begin
            w_push[k] = bus.in_valid && w_in_ready && (bus.in_sel == 1'(k));
            w_pop[k]  = w_valid[k] && w_sink_ready[k];
        end
    end

    // Pointers, occupancy and pop counters; storage is left out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                r_wptr[k] <= '0;
                r_rptr[k] <= '0;
                r_occ[k]  <= '0;
                r_cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (w_push[k]) begin
                    r_wptr[k] <= r_wptr[k] + PTR_W'(1);
                end
                if (w_pop[k]) begin
                    r_rptr[k] <= r_rptr[k] + PTR_W'(1);
                    r_cnt[k]  <= r_cnt[k] + CNT_W'(1);
                end
                case ({w_push[k], w_pop[k]})
                    2'b10:   r_occ[k] <= r_occ[k] + OCC_W'(1);
                    2'b01:   r_occ[k] <= r_occ[k] - OCC_W'(1);
                    default: r_occ[k] <= r_occ[k];
                endcase
            end
        end
    end

    // Word storage: written at the selected FIFO's write pointer on push.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (w_push[k]) begin
                r_mem[k][r_wptr[k]] <= bus.in_data;
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.a_valid  = w_valid[0];
    assign bus.a_data   = w_head[0];
    assign bus.a_cnt    = r_cnt[0];
    assign bus.b_valid  = w_valid[1];
    assign bus.b_data   = w_head[1];
    assign bus.b_cnt    = r_cnt[1];

endmodule
